// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the two-port BurstRAM arbiter.
// Ports: none (package). Holds the FSM state encoding, port ids and command codes.
// Imported by burst_ram_arbiter.
package burst_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic PORT_I    = 1'b0;
    localparam logic PORT_D    = 1'b1;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter.sv
// Shares one BurstRAM between the I-cache (port 0) and the D-cache (port 1), one burst per grant, round-robin.
// Ports: clk/rst; per port pN_cmd/cmd_en/addr/wr_data/data_mask in, pN_rd_data/rd_data_valid/busy out;
//        br_* command outputs to the RAM, br_rd_data/rd_data_valid/busy from the RAM; err sticky protocol error.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 8,
    parameter int DATA_BITWIDTH    = 64,
    parameter int BURST_COUNT      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         p0_cmd,
    input  logic                         p0_cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0]  p0_addr,
    input  logic [DATA_BITWIDTH-1:0]     p0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   p0_data_mask,
    output logic [DATA_BITWIDTH-1:0]     p0_rd_data,
    output logic                         p0_rd_data_valid,
    output logic                         p0_busy,
    input  logic                         p1_cmd,
    input  logic                         p1_cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0]  p1_addr,
    input  logic [DATA_BITWIDTH-1:0]     p1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   p1_data_mask,
    output logic [DATA_BITWIDTH-1:0]     p1_rd_data,
    output logic                         p1_rd_data_valid,
    output logic                         p1_busy,
    output logic                         br_cmd,
    output logic                         br_cmd_en,
    output logic [ADDRESS_BITWIDTH-1:0]  br_addr,
    output logic [DATA_BITWIDTH-1:0]     br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]   br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]     br_rd_data,
    input  logic                         br_rd_data_valid,
    input  logic                         br_busy,
    output logic                         err
);

    localparam int              BW   = $clog2(BURST_COUNT) + 1;
    localparam int              MW   = DATA_BITWIDTH / 8;
    localparam logic [BW-1:0]   LAST = BW'(BURST_COUNT);

    state_e          state_q, state_d;
    logic            token_q, token_d;
    logic            owner_q, owner_d;
    logic [BW-1:0]   beat_q,  beat_d;
    logic            err_q,   err_d;

    // Per-port views so the mux and the per-port outputs index by port id.
    logic                         cmd_a     [2];
    logic                         cmd_en_a  [2];
    logic [ADDRESS_BITWIDTH-1:0]  addr_a    [2];
    logic [DATA_BITWIDTH-1:0]     wr_data_a [2];
    logic [MW-1:0]                mask_a    [2];
    logic [1:0]                   busy_a;
    logic [1:0]                   valid_a;

    assign cmd_a[0]     = p0_cmd;       assign cmd_a[1]     = p1_cmd;
    assign cmd_en_a[0]  = p0_cmd_en;    assign cmd_en_a[1]  = p1_cmd_en;
    assign addr_a[0]    = p0_addr;      assign addr_a[1]    = p1_addr;
    assign wr_data_a[0] = p0_wr_data;   assign wr_data_a[1] = p1_wr_data;
    assign mask_a[0]    = p0_data_mask; assign mask_a[1]    = p1_data_mask;

    // In IDLE the token port drives the RAM; during a burst the owner keeps it.
    logic sel;
    logic accept;
    logic proto_err;

    assign sel    = (state_q == IDLE) ? token_q : owner_q;
    assign accept = (state_q == IDLE) && cmd_en_a[token_q] && !br_busy;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            assign busy_a[p]  = (state_q == IDLE && token_q == 1'(p)) ? br_busy : 1'b1;
            assign valid_a[p] = (state_q == READ && owner_q == 1'(p)) ? br_rd_data_valid : 1'b0;
        end
    endgenerate

    assign p0_busy          = busy_a[0];
    assign p1_busy          = busy_a[1];
    assign p0_rd_data_valid = valid_a[0];
    assign p1_rd_data_valid = valid_a[1];
    assign p0_rd_data       = br_rd_data;
    assign p1_rd_data       = br_rd_data;

    assign br_cmd       = cmd_a[sel];
    assign br_cmd_en    = accept;
    assign br_addr      = addr_a[sel];
    assign br_wr_data   = wr_data_a[sel];
    assign br_data_mask = mask_a[sel];

    assign proto_err = (p0_cmd_en && busy_a[0]) || (p1_cmd_en && busy_a[1]) ||
                       (br_rd_data_valid && state_q != READ);
    assign err = err_q;

    always_comb begin
        state_d = state_q;
        token_d = token_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        err_d   = err_q | proto_err;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = token_q;
                    // Write beat 0 travels with the command, so a write starts one beat in.
                    if (cmd_a[token_q] == CMD_WRITE) begin
                        beat_d  = BW'(1);
                        state_d = WRITE;
                    end else begin
                        beat_d  = '0;
                        state_d = READ;
                    end
                end else begin
                    token_d = ~token_q;
                end
            end
            WRITE: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST - 1'b1) state_d = RELEASE;
            end
            READ: begin
                if (br_rd_data_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST - 1'b1) state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Offer the other port first so neither cache can starve its peer.
                if (!br_busy) begin
                    token_d = ~owner_q;
                    beat_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            token_q <= PORT_I;
            owner_q <= PORT_I;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            token_q <= token_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
module tb_burst_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int BC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           cmd     [2];
    logic           cmd_en  [2];
    logic [AW-1:0]  addr    [2];
    logic [DW-1:0]  wr_data [2];
    logic [MW-1:0]  mask    [2];
    logic [DW-1:0]  rd_data [2];
    logic           vld     [2];
    logic           busy    [2];

    logic           br_cmd, br_cmd_en;
    logic [AW-1:0]  br_addr;
    logic [DW-1:0]  br_wr_data;
    logic [MW-1:0]  br_mask;
    logic [DW-1:0]  br_rd_data;
    logic           br_vld, br_busy;
    logic           err;

    burst_ram_arbiter #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst(rst),
        .p0_cmd(cmd[0]), .p0_cmd_en(cmd_en[0]), .p0_addr(addr[0]), .p0_wr_data(wr_data[0]),
        .p0_data_mask(mask[0]), .p0_rd_data(rd_data[0]), .p0_rd_data_valid(vld[0]), .p0_busy(busy[0]),
        .p1_cmd(cmd[1]), .p1_cmd_en(cmd_en[1]), .p1_addr(addr[1]), .p1_wr_data(wr_data[1]),
        .p1_data_mask(mask[1]), .p1_rd_data(rd_data[1]), .p1_rd_data_valid(vld[1]), .p1_busy(busy[1]),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_vld), .br_busy(br_busy),
        .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_on = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- BurstRAM model: 3-cycle read latency, 4-beat bursts ----------------
    logic [DW-1:0] mem [256];
    logic          r_act = 1'b0, w_act = 1'b0;
    int            r_cnt, w_beat;
    logic [AW-1:0] r_addr, w_addr;
    assign br_busy = r_act | w_act;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r = old;
        for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            r_act <= 1'b0; w_act <= 1'b0; br_vld <= 1'b0; r_cnt <= 0; w_beat <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
        end else begin
            br_vld <= 1'b0;
            if (br_cmd_en && !br_busy) begin
                if (br_cmd) begin
                    mem[br_addr] <= merge(mem[br_addr], br_wr_data, br_mask);
                    w_act <= 1'b1; w_beat <= 1; w_addr <= br_addr;
                end else begin
                    r_act <= 1'b1; r_cnt <= 0; r_addr <= br_addr;
                end
            end
            if (r_act) begin
                if (r_cnt >= 1) begin
                    br_vld     <= 1'b1;
                    br_rd_data <= mem[r_addr + AW'(r_cnt - 1)];
                end
                if (r_cnt == BC) r_act <= 1'b0;
                r_cnt <= r_cnt + 1;
            end
            if (w_act) begin
                mem[w_addr + AW'(w_beat)] <= merge(mem[w_addr + AW'(w_beat)], br_wr_data, br_mask);
                if (w_beat == BC - 1) w_act <= 1'b0;
                w_beat <= w_beat + 1;
            end
        end
    end

    // ---------------- Arbiter model: transaction view (free/held, beats outstanding) ----------------
    bit m_idle = 1, m_tok = 0, m_own = 0, m_rd = 0, m_err = 0;
    int m_left = 0;

    function automatic logic e_busy(input int p);
        return (m_idle && int'(m_tok) == p) ? br_busy : 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_idle = 1; m_tok = 0; m_own = 0; m_rd = 0; m_left = 0; m_err = 0;
        end else begin
            if ((cmd_en[0] && e_busy(0)) || (cmd_en[1] && e_busy(1))) m_err = 1;
            if (br_vld && !(!m_idle && m_rd && m_left > 0)) m_err = 1;
            if (m_idle) begin
                if (cmd_en[m_tok] && !br_busy) begin
                    m_idle = 0; m_own = m_tok; m_rd = !cmd[m_tok];
                    m_left = m_rd ? BC : BC - 1;
                end else begin
                    m_tok = !m_tok;
                end
            end else if (m_left > 0) begin
                if (!m_rd || br_vld) m_left--;
            end else if (!br_busy) begin
                m_idle = 1; m_tok = !m_own;
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        logic e_en;
        e_en = m_idle && cmd_en[m_tok] && !br_busy;
        check("p0_busy", busy[0], e_busy(0));
        check("p1_busy", busy[1], e_busy(1));
        check("br_cmd_en", br_cmd_en, e_en);
        check("p0_valid", vld[0], (!m_idle && m_rd && m_left > 0 && !m_own) ? br_vld : 1'b0);
        check("p1_valid", vld[1], (!m_idle && m_rd && m_left > 0 &&  m_own) ? br_vld : 1'b0);
        check("err", err, m_err);
        if (e_en) begin
            check("br_cmd", br_cmd, cmd[m_tok]);
            check("br_addr", br_addr, addr[m_tok]);
            check("br_wr_data_b0", br_wr_data, wr_data[m_tok]);
        end
        if (!m_idle && !m_rd && m_left > 0) begin
            check("br_wr_data", br_wr_data, wr_data[m_own]);
            check("br_mask", br_mask, mask[m_own]);
        end
        if (vld[0]) check("p0_rd_data", rd_data[0], br_rd_data);
        if (vld[1]) check("p1_rd_data", rd_data[1], br_rd_data);
    end

    // ---------------- Capture and port agents ----------------
    logic [DW-1:0] rx0[$], rx1[$];
    int            glog[$], gcyc[$];

    always @(posedge clk) begin
        if (vld[0]) rx0.push_back(rd_data[0]);
        if (vld[1]) rx1.push_back(rd_data[1]);
    end

    task automatic port_op(input int p, input logic wr, input logic [AW-1:0] a,
                           input logic [3:0][DW-1:0] d);
        int t = 0;
        cmd[p] = wr; addr[p] = a; wr_data[p] = d[0]; mask[p] = '1;
        while (busy[p] !== 1'b0 && t < 200) begin @(posedge clk); #1; t++; end
        n_cmp++;
        if (t >= 200) begin
            n_bad++;
            $display("FAIL grant_wait port %0d: waited %0d cycles, limit 200", p, t);
            return;
        end
        cmd_en[p] = 1'b1;
        glog.push_back(p);
        gcyc.push_back(cyc);
        @(posedge clk); #1;
        cmd_en[p] = 1'b0;
        if (wr) for (int b = 1; b < BC; b++) begin
            wr_data[p] = d[b];
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_rx(input int p, input int n);
        int t = 0;
        while (((p == 0) ? rx0.size() : rx1.size()) < n && t < 200) begin @(negedge clk); t++; end
        n_cmp++;
        if (t >= 200) begin
            n_bad++;
            $display("FAIL rx_wait port %0d: got %0d beats, need %0d", p,
                     (p == 0) ? rx0.size() : rx1.size(), n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    localparam logic [3:0][DW-1:0] NOD = '0;
    localparam logic [3:0][DW-1:0] WPAT = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    initial begin
        for (int p = 0; p < 2; p++) begin
            cmd[p] = 0; cmd_en[p] = 0; addr[p] = '0; wr_data[p] = '0; mask[p] = '1;
        end
        repeat (2) @(posedge clk);
        #1 chk_on = 1;
        @(negedge clk);
        check("rst_p0_busy", busy[0], 1'b0);
        check("rst_p1_busy", busy[1], 1'b1);
        check("rst_p0_valid", vld[0], 1'b0);
        check("rst_p1_valid", vld[1], 1'b0);
        check("rst_br_cmd_en", br_cmd_en, 1'b0);
        check("rst_err", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read from p0 at address 0
        port_op(0, 1'b0, 8'd0, NOD);
        wait_rx(0, 4);
        check("rd0_w0", rx0[0], 64'hC0DE_0000_0000_0000);
        check("rd0_w1", rx0[1], 64'hC0DE_0000_0000_0001);
        check("rd0_w3", rx0[3], 64'hC0DE_0000_0000_0003);
        check("rd0_p1_beats", rx1.size(), 0);

        // p1 writes addr 8, p0 reads it back
        rx0.delete();
        port_op(1, 1'b1, 8'd8, WPAT);
        port_op(0, 1'b0, 8'd8, NOD);
        wait_rx(0, 4);
        check("wr_rd_w0", rx0[0], 64'h1111_1111_1111_1111);
        check("wr_rd_w1", rx0[1], 64'h2222_2222_2222_2222);
        check("wr_rd_w2", rx0[2], 64'h3333_3333_3333_3333);
        check("wr_rd_w3", rx0[3], 64'h4444_4444_4444_4444);

        // Contention: both request right after reset; p0 first, p1 8 cycles later
        do_reset();
        rx0.delete(); rx1.delete(); glog.delete(); gcyc.delete();
        fork
            port_op(0, 1'b0, 8'd16, NOD);
            port_op(1, 1'b0, 8'd20, NOD);
        join
        wait_rx(0, 4);
        wait_rx(1, 4);
        check("cont_first", glog[0], 0);
        check("cont_second", glog[1], 1);
        check("cont_gap", gcyc[1] - gcyc[0], 8);
        check("cont_p0_w0", rx0[0], 64'hC0DE_0000_0000_0010);
        check("cont_p1_w0", rx1[0], 64'hC0DE_0000_0000_0014);
        check("cont_p1_w3", rx1[3], 64'hC0DE_0000_0000_0017);

        // Fairness: p0 back-to-back, p1 continuously requesting
        do_reset();
        rx0.delete(); rx1.delete(); glog.delete(); gcyc.delete();
        fork
            begin
                port_op(0, 1'b0, 8'd32, NOD);
                port_op(0, 1'b0, 8'd36, NOD);
                port_op(0, 1'b0, 8'd40, NOD);
            end
            begin
                port_op(1, 1'b0, 8'd48, NOD);
                port_op(1, 1'b0, 8'd52, NOD);
            end
        join
        wait_rx(0, 12);
        wait_rx(1, 8);
        check("fair_g0", glog[0], 0);
        check("fair_g1", glog[1], 1);
        check("fair_g2", glog[2], 0);
        check("fair_g3", glog[3], 1);
        check("fair_g4", glog[4], 0);
        check("fair_p0_w4", rx0[4], 64'hC0DE_0000_0000_0024);
        check("fair_p1_w4", rx1[4], 64'hC0DE_0000_0000_0034);

        // Protocol error: p1 strobes while p0 owns a burst
        do_reset();
        rx0.delete();
        port_op(0, 1'b0, 8'd0, NOD);
        cmd[1] = 1'b0; addr[1] = 8'd4;
        cmd_en[1] = 1'b1;
        @(negedge clk);
        check("perr_br_cmd_en", br_cmd_en, 1'b0);
        @(posedge clk); #1;
        cmd_en[1] = 1'b0;
        @(negedge clk);
        check("perr_err_set", err, 1'b1);
        wait_rx(0, 4);
        repeat (4) @(negedge clk);
        check("perr_err_held", err, 1'b1);
        do_reset();
        @(negedge clk);
        check("perr_err_cleared", err, 1'b0);

        // Reset during beat 2 of a read
        @(posedge clk); #1;
        do_reset();
        rx0.delete();
        port_op(0, 1'b0, 8'd0, NOD);
        wait_rx(0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_p0_valid", vld[0], 1'b0);
        check("mrst_p1_valid", vld[1], 1'b0);
        check("mrst_p0_busy", busy[0], 1'b0);
        check("mrst_p1_busy", busy[1], 1'b1);
        check("mrst_beats", rx0.size(), 3);
        repeat (10) @(negedge clk);
        check("mrst_no_more_beats", rx0.size(), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
